pixel_unpacker: RTL and testbench

- Parametrised successor to the fixed 8-pixel splitter in the VGA path.
- Accepts wide frame-buffer words (WORD_W bits) over a valid/ready handshake and emits PIX_W-bit pixels one per cycle over a second valid/ready handshake.
- Generates the frame-buffer word address with frame wrap and an end-of-frame pulse.
- Sits between the frame-buffer read port and the VGA pixel pipeline.

---
 rtl/pixel_unpacker.sv | 127 ++++++++++++
 tb/tb_pixel_unpacker.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: splits WORD_W-bit frame-buffer words into PIX_W-bit pixels.
// Words arrive on a valid/ready handshake (in_*) and pixels leave one per
// cycle on a second valid/ready handshake (pix_*). The block also walks the
// frame-buffer word address (mem_addr) with frame wrap and pulses frame_end
// for one cycle after the last word of a frame is accepted.
// Build option: define UNPACK_LSB_FIRST_EN to emit pixel 0 from the least
// significant slice of the word; default order is MSB-first.
module pixel_unpacker #(
    parameter int WORD_W      = 192,
    parameter int PIX_W       = 24,
    parameter int ADDR_W      = 13,
    parameter int FRAME_WORDS = 4800
) (
    input  logic              wrclk,
    input  logic              rst_n,
    input  logic              sync_clr,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PIX_W-1:0]  pix_q,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              frame_end
);

    localparam int PPW   = WORD_W / PIX_W;
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int SLOTS = 2 ** IDX_W;

    // Parameter sanity, caught at elaboration.
    if ((WORD_W % PIX_W) != 0) begin : g_err_div
        $error("pixel_unpacker: WORD_W must be a multiple of PIX_W");
    end
    if (PPW < 2) begin : g_err_ppw
        $error("pixel_unpacker: WORD_W/PIX_W must be at least 2");
    end
    if ((FRAME_WORDS < 2) || (FRAME_WORDS > (2 ** ADDR_W))) begin : g_err_frame
        $error("pixel_unpacker: FRAME_WORDS must be within 2..2**ADDR_W");
    end

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              frame_end_q, frame_end_d;

    logic              accept_s;
    logic              consume_s;
    logic              last_s;
    logic              wrap_s;
    logic [PIX_W-1:0]  slot_s [SLOTS];

    // Slice the holding word into pixel slots; unused slots (non power-of-two
    // PPW) read as zero and are never selected.
    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        if (k < PPW) begin : g_real
`ifdef UNPACK_LSB_FIRST_EN
            assign slot_s[k] = word_q[k*PIX_W +: PIX_W];
`else
            assign slot_s[k] = word_q[WORD_W-1-k*PIX_W -: PIX_W];
`endif
        end else begin : g_pad
            assign slot_s[k] = '0;
        end
    end

    assign pix_q     = slot_s[idx_q];
    assign pix_valid = full_q;
    assign mem_addr  = addr_q;
    assign frame_end = frame_end_q;

    // Handshake decode; in_ready reopens on the last pixel so words stream without a bubble.
    always_comb begin
        consume_s = full_q & pix_ready;
        last_s    = consume_s & (idx_q == IDX_W'(PPW - 1));
        in_ready  = ~full_q | last_s;
        accept_s  = in_valid & in_ready;
        wrap_s    = (addr_q == ADDR_W'(FRAME_WORDS - 1));
    end

    // Next-state: clear beats accept, accept beats last, last beats plain consume.
    always_comb begin
        word_d      = word_q;
        idx_d       = idx_q;
        full_d      = full_q;
        addr_d      = addr_q;
        frame_end_d = 1'b0;
        if (sync_clr) begin
            word_d = '0;
            idx_d  = '0;
            full_d = 1'b0;
            addr_d = '0;
        end else if (accept_s) begin
            word_d      = in_data;
            idx_d       = '0;
            full_d      = 1'b1;
            addr_d      = wrap_s ? '0 : (addr_q + ADDR_W'(1));
            frame_end_d = wrap_s;
        end else if (last_s) begin
            idx_d  = '0;
            full_d = 1'b0;
        end else if (consume_s) begin
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge wrclk or negedge rst_n) begin
        if (!rst_n) begin
            word_q      <= '0;
            idx_q       <= '0;
            full_q      <= 1'b0;
            addr_q      <= '0;
            frame_end_q <= 1'b0;
        end else begin
            word_q      <= word_d;
            idx_q       <= idx_d;
            full_q      <= full_d;
            addr_q      <= addr_d;
            frame_end_q <= frame_end_d;
        end
    end

endmodule

// File: tb/tb_pixel_unpacker.sv
// Self-checking bench for pixel_unpacker: a directed vector table, hand-written
// corner-case sequences and a randomized run, all compared against a
// queue-based pixel model. Honours UNPACK_LSB_FIRST_EN in the model.
module tb_pixel_unpacker;

    localparam int W   = 192;
    localparam int P   = 24;
    localparam int A   = 13;
    localparam int FW  = 4;
    localparam int PPW = W / P;

    logic         wrclk    = 1'b0;
    logic         rst_n    = 1'b1;
    logic         sync_clr = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [P-1:0] pix_q;
    logic         pix_valid;
    logic         pix_ready = 1'b0;
    logic [A-1:0] mem_addr;
    logic         frame_end;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Reference model: pixels still owed from the held word, plus address state.
    logic [P-1:0] mq[$];
    int           m_addr = 0;
    bit           m_fe   = 1'b0;
    bit           mon_en = 1'b0;

    typedef struct {
        bit           iv;
        bit           pr;
        bit           e_pv;
        logic [P-1:0] e_pix;
        bit           e_ir;
    } vec_t;
    vec_t vt[10];

    pixel_unpacker #(
        .WORD_W(W), .PIX_W(P), .ADDR_W(A), .FRAME_WORDS(FW)
    ) dut (
        .wrclk(wrclk), .rst_n(rst_n), .sync_clr(sync_clr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pix_q(pix_q), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .mem_addr(mem_addr), .frame_end(frame_end)
    );

    always #5 wrclk = ~wrclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [P-1:0] pix_of(input logic [W-1:0] w, input int k);
`ifdef UNPACK_LSB_FIRST_EN
        return w[k*P +: P];
`else
        return w[W-1-k*P -: P];
`endif
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < W/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Physical word with value k+1 in the k-th slice counted from the MSB end.
    function automatic logic [W-1:0] seq_word();
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < PPW; k++) w[W-1-k*P -: P] = P'(k + 1);
        return w;
    endfunction

    task automatic step();
        @(posedge wrclk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        pix_ready = 1'b0;
        sync_clr  = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge wrclk);
        #1 rst_n = 1'b1;
    endtask

    // Drive in_valid until the word is taken, bounded to 20 cycles.
    task automatic wait_acc(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge wrclk);
            if (in_valid && in_ready) begin
                ok = 1'b1;
                step();
                return;
            end
            step();
        end
    endtask

    // Monitor: compare outputs with the model mid-cycle, then advance the model
    // by what the coming edge will do.
    initial begin
        bit exp_ir;
        bit acc;
        forever begin
            @(negedge wrclk);
            if (mon_en) begin
                if (!rst_n) begin
                    chk("rst_pix_valid", 64'(pix_valid), 64'(0));
                    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
                    mq.delete();
                    m_addr = 0;
                    m_fe   = 1'b0;
                end else begin
                    exp_ir = (mq.size() == 0) || ((mq.size() == 1) && pix_ready);
                    chk("mdl_pix_valid", 64'(pix_valid), 64'(mq.size() > 0));
                    if (mq.size() > 0) chk("mdl_pix_q", 64'(pix_q), 64'(mq[0]));
                    chk("mdl_in_ready", 64'(in_ready), 64'(exp_ir));
                    chk("mdl_mem_addr", 64'(mem_addr), 64'(m_addr));
                    chk("mdl_frame_end", 64'(frame_end), 64'(m_fe));
                    if (sync_clr) begin
                        mq.delete();
                        m_addr = 0;
                        m_fe   = 1'b0;
                    end else begin
                        acc  = in_valid && exp_ir;
                        m_fe = 1'b0;
                        if ((mq.size() > 0) && pix_ready) void'(mq.pop_front());
                        if (acc) begin
                            for (int k = 0; k < PPW; k++) mq.push_back(pix_of(in_data, k));
                            m_fe   = (m_addr == FW - 1);
                            m_addr = (m_addr + 1) % FW;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] sw[3];
        logic [W-1:0] w;
        int vcnt, irh, nacc, first, lastc, e;
        int exp_addr[5];
        bit took, ok;

        #1;
        mon_en = 1'b1;

        // Reset / idle
        do_reset();
        @(negedge wrclk);
        chk("idle_pix_valid", 64'(pix_valid), 64'(0));
        chk("idle_in_ready", 64'(in_ready), 64'(1));
        chk("idle_mem_addr", 64'(mem_addr), 64'(0));
        chk("idle_frame_end", 64'(frame_end), 64'(0));
        step();

        // Single word, table driven
        vt[0] = '{iv: 1'b1, pr: 1'b1, e_pv: 1'b0, e_pix: '0, e_ir: 1'b1};
        for (int r = 1; r <= PPW; r++) begin
`ifdef UNPACK_LSB_FIRST_EN
            e = PPW + 1 - r;
`else
            e = r;
`endif
            vt[r] = '{iv: 1'b0, pr: 1'b1, e_pv: 1'b1, e_pix: P'(e), e_ir: (r == PPW)};
        end
        vt[9] = '{iv: 1'b0, pr: 1'b1, e_pv: 1'b0, e_pix: '0, e_ir: 1'b1};
        in_data = seq_word();
        for (int r = 0; r < 10; r++) begin
            in_valid  = vt[r].iv;
            pix_ready = vt[r].pr;
            @(negedge wrclk);
            chk("tbl_pix_valid", 64'(pix_valid), 64'(vt[r].e_pv));
            if (vt[r].e_pv) chk("tbl_pix_q", 64'(pix_q), 64'(vt[r].e_pix));
            chk("tbl_in_ready", 64'(in_ready), 64'(vt[r].e_ir));
            step();
        end
        chk("tbl_mem_addr", 64'(mem_addr), 64'(1));

        // Streaming three words with no bubble
        do_reset();
        for (int i = 0; i < 3; i++) sw[i] = rand_word();
        in_data = sw[0]; in_valid = 1'b1; pix_ready = 1'b1;
        vcnt = 0; irh = 0; nacc = 0; first = -1; lastc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge wrclk);
            took = in_valid && in_ready;
            if (pix_valid) begin
                vcnt++;
                if (first < 0) first = c;
                lastc = c;
                if (in_ready) irh++;
            end
            step();
            if (took) begin
                nacc++;
                if (nacc < 3) in_data = sw[nacc];
                else in_valid = 1'b0;
            end
        end
        chk("stream_valid_count", 64'(vcnt), 64'(24));
        chk("stream_span", 64'(lastc - first + 1), 64'(24));
        chk("stream_ready_while_full", 64'(irh), 64'(3));
        chk("stream_accepts", 64'(nacc), 64'(3));
        chk("stream_mem_addr", 64'(mem_addr), 64'(3));

        // Backpressure at idx 3
        do_reset();
        w = rand_word();
        in_data = w; in_valid = 1'b1; pix_ready = 1'b1;
        wait_acc(ok);
        in_valid = 1'b0;
        chk("bp_accept", 64'(ok), 64'(1));
        repeat (3) step();
        pix_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge wrclk);
            chk("bp_hold_pix", 64'(pix_q), 64'(pix_of(w, 3)));
            chk("bp_hold_ready", 64'(in_ready), 64'(0));
            step();
        end
        pix_ready = 1'b1;
        @(negedge wrclk);
        chk("bp_resume_pix", 64'(pix_q), 64'(pix_of(w, 3)));
        step();
        @(negedge wrclk);
        chk("bp_next_pix", 64'(pix_q), 64'(pix_of(w, 4)));
        repeat (6) step();

        // Frame wrap with FRAME_WORDS = 4
        do_reset();
        exp_addr = '{1, 2, 3, 0, 1};
        pix_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = rand_word();
            in_valid = 1'b1;
            wait_acc(ok);
            in_valid = 1'b0;
            chk("wrap_accept", 64'(ok), 64'(1));
            chk("wrap_mem_addr", 64'(mem_addr), 64'(exp_addr[i]));
            chk("wrap_frame_end", 64'(frame_end), 64'(i == 3));
            if (i == 3) begin
                step();
                chk("wrap_frame_end_drop", 64'(frame_end), 64'(0));
            end
        end
        repeat (9) step();

        // Asynchronous reset at idx 5
        do_reset();
        in_data = rand_word(); in_valid = 1'b1; pix_ready = 1'b1;
        wait_acc(ok);
        in_valid = 1'b0;
        repeat (5) step();
        chk("arst_pre_addr", 64'(mem_addr), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_pix_valid", 64'(pix_valid), 64'(0));
        chk("arst_mem_addr", 64'(mem_addr), 64'(0));
        repeat (2) step();
        rst_n = 1'b1;

        // Synchronous clear at idx 5, then clear against a same-cycle accept
        in_data = rand_word(); in_valid = 1'b1; pix_ready = 1'b1;
        wait_acc(ok);
        in_valid = 1'b0;
        repeat (5) step();
        sync_clr = 1'b1; in_data = rand_word(); in_valid = 1'b1;
        @(negedge wrclk);
        chk("sclr_pre_valid", 64'(pix_valid), 64'(1));
        step();
        sync_clr = 1'b0; in_valid = 1'b0;
        chk("sclr_pix_valid", 64'(pix_valid), 64'(0));
        chk("sclr_mem_addr", 64'(mem_addr), 64'(0));
        chk("sclr_frame_end", 64'(frame_end), 64'(0));
        sync_clr = 1'b1; in_data = rand_word(); in_valid = 1'b1;
        @(negedge wrclk);
        chk("sclr_acc_ready", 64'(in_ready), 64'(1));
        step();
        sync_clr = 1'b0; in_valid = 1'b0;
        chk("sclr_acc_dropped", 64'(pix_valid), 64'(0));
        chk("sclr_acc_addr", 64'(mem_addr), 64'(0));

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge wrclk);
            took = in_valid && in_ready;
            step();
            if (!in_valid || took || sync_clr) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = rand_word();
            end
            pix_ready = ($urandom_range(0, 3) != 0);
            sync_clr  = ($urandom_range(0, 63) == 0);
        end
        sync_clr = 1'b0; in_valid = 1'b0; pix_ready = 1'b1;
        repeat (12) step();
        @(negedge wrclk);
        chk("drain_pix_valid", 64'(pix_valid), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
